// File: rtl/huffman_pkg.sv
// huffman_pkg: shared constants, symbol ids, FSM state type and popcount helper
//   NSYM/CODE_W/OUT_W : table size, per-entry width (= max code length), output width
//   A1..A6            : legal symbol ids
//   state_t           : IDLE (no table), RUN (encoding), FLUSH (draining)
package huffman_pkg;
  localparam int NSYM   = 6;
  localparam int CODE_W = 8;
  localparam int OUT_W  = 8;
  localparam logic [7:0] A1 = 8'd1;
  localparam logic [7:0] A2 = 8'd2;
  localparam logic [7:0] A3 = 8'd3;
  localparam logic [7:0] A4 = 8'd4;
  localparam logic [7:0] A5 = 8'd5;
  localparam logic [7:0] A6 = 8'd6;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  function automatic logic [3:0] popcount(input logic [CODE_W-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < CODE_W; i++) c = c + {3'b0, v[i]};
    return c;
  endfunction
endpackage

// File: rtl/huffman_bit_packer.sv
// huffman_bit_packer: MSB-first bit accumulator with byte emission and zero-pad
//   app_en/app_code/app_len : append the low app_len bits of app_code
//   pad_en                  : allow a partial remainder to be padded and emitted as last
//   out_valid/out_data/out_last/out_ready : output byte handshake
//   cnt                     : number of valid bits held in acc
module huffman_bit_packer
  import huffman_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              app_en,
  input  logic [CODE_W-1:0] app_code,
  input  logic [3:0]        app_len,
  input  logic              pad_en,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_last,
  output logic [3:0]        cnt
);
  // acc is left-justified: valid bits occupy acc[14 -: cnt], everything below is zero,
  // so the top byte is directly the next output and padding comes for free.
  logic [14:0] acc;
  logic [14:0] app_bits;
  logic        slot_free;
  logic        emit;
  logic        pad;
  assign slot_free = !out_valid || out_ready;
  assign emit      = (cnt >= 4'd8) && slot_free;
  assign pad       = pad_en && (cnt != 4'd0) && (cnt < 4'd8) && slot_free;
  // left-justify the code to bit 14, then slide it below the bits already held
  assign app_bits  = ({app_code, 7'b0} << (4'd8 - app_len)) >> cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      if (emit) begin
        acc <= acc << 8;
        cnt <= cnt - 4'd8;
      end else if (pad) begin
        acc <= '0;
        cnt <= '0;
      end else if (app_en) begin
        acc <= acc | app_bits;
        cnt <= cnt + app_len;
      end
      if (emit || pad) begin
        out_valid <= 1'b1;
        out_data  <= acc[14:7];
        out_last  <= pad;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
endmodule

// File: rtl/huffman_stream_encoder.sv
// huffman_stream_encoder: table-driven Huffman symbol encoder producing a packed byte stream
//   code_valid/HC/M      : table load (A1 in [47:40] .. A6 in [7:0])
//   sym_valid/sym_data/sym_ready : symbol input handshake (ids 1..6)
//   flush/flush_done     : stream termination request and completion pulse
//   out_valid/out_data/out_last/out_ready : packed byte output, first code bit in bit 7
//   err_sym              : pulse after an illegal symbol is consumed
module huffman_stream_encoder
  import huffman_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   code_valid,
  input  logic [NSYM*CODE_W-1:0] HC,
  input  logic [NSYM*CODE_W-1:0] M,
  input  logic                   sym_valid,
  input  logic [7:0]             sym_data,
  output logic                   sym_ready,
  input  logic                   flush,
  output logic                   out_valid,
  output logic [7:0]             out_data,
  output logic                   out_last,
  input  logic                   out_ready,
  output logic                   flush_done,
  output logic                   err_sym
);
  state_t            state, state_n;
  logic [CODE_W-1:0] hc_t [NSYM];
  logic [CODE_W-1:0] m_t  [NSYM];
  logic [3:0]        cnt;
  logic [3:0]        len;
  logic [2:0]        idx;
  logic              in_range, legal, accept, load, done_n, last_xfer;
  assign sym_ready = (state == RUN) && (cnt < 4'd8);
  assign accept    = sym_valid && sym_ready;
  assign in_range  = (sym_data >= A1) && (sym_data <= A6);
  assign idx       = in_range ? sym_data[2:0] - 3'd1 : 3'd0;
  assign len       = popcount(m_t[idx]);
  assign legal     = in_range && (len != 4'd0);
  assign load      = code_valid && (state != FLUSH);
  assign last_xfer = out_valid && out_ready && out_last;
  huffman_bit_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .app_en    (accept && legal),
    .app_code  (hc_t[idx] & m_t[idx]),
    .app_len   (len),
    .pad_en    (state == FLUSH),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .cnt       (cnt)
  );
  // FLUSH ends either when the padded last byte is taken, or when nothing is left to pad
  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    if (state == IDLE && code_valid) state_n = RUN;
    else if (state == RUN && flush) state_n = FLUSH;
    else if (state == FLUSH && (last_xfer || (cnt == 4'd0 && !(out_valid && out_last)))) begin
      state_n = RUN;
      done_n  = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state      <= IDLE;
      flush_done <= 1'b0;
      err_sym    <= 1'b0;
      for (int i = 0; i < NSYM; i++) begin
        hc_t[i] <= '0;
        m_t[i]  <= '0;
      end
    end else begin
      state      <= state_n;
      flush_done <= done_n;
      err_sym    <= accept && !legal;
      if (load)
        for (int i = 0; i < NSYM; i++) begin
          hc_t[i] <= HC[(NSYM-1-i)*CODE_W +: CODE_W];
          m_t[i]  <= M[(NSYM-1-i)*CODE_W +: CODE_W];
        end
    end
endmodule
